// File: rtl/vm1_dma_arb_if.sv
// ----------------------------------------------------------------------------
// vm1_dma_arb_if
//   Bundles the local DMA request/grant lines and the Qbus arbitration pins
//   used by vm1_dma_arb.
//
//   master : arbiter side (drives gnt, DMR, DMGO, SACK, busy, tmo)
//   slave  : environment side (requesters and bus pins)
//
//   req          NREQ  level DMA requests, held until done with the bus
//   gnt          NREQ  one-hot grant, requester owns the bus while high
//   pin_dmr_out  1     bus request, open-collector drive enable
//   pin_dmgi     1     bus grant in (daisy chain)
//   pin_dmgo     1     bus grant out (daisy chain)
//   pin_sack_in  1     SACK line sensed (wired-OR)
//   pin_sack_out 1     SACK drive enable
//   pin_sync_in  1     SYNC sensed, bus cycle in progress
//   pin_rply_in  1     RPLY sensed
//   busy         1     arbiter not idle
//   tmo          1     one-cycle pulse on grant timeout abort
// ----------------------------------------------------------------------------
interface vm1_dma_arb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            pin_dmr_out;
    logic            pin_dmgi;
    logic            pin_dmgo;
    logic            pin_sack_in;
    logic            pin_sack_out;
    logic            pin_sync_in;
    logic            pin_rply_in;
    logic            busy;
    logic            tmo;

    modport master (
        input  req, pin_dmgi, pin_sack_in, pin_sync_in, pin_rply_in,
        output gnt, pin_dmr_out, pin_dmgo, pin_sack_out, busy, tmo
    );

    modport slave (
        output req, pin_dmgi, pin_sack_in, pin_sync_in, pin_rply_in,
        input  gnt, pin_dmr_out, pin_dmgo, pin_sack_out, busy, tmo
    );
endinterface

// File: rtl/vm1_dma_arb.sv
// ----------------------------------------------------------------------------
// vm1_dma_arb
//   Qbus DMA arbiter/sequencer for the vm1 core. Collects NREQ local DMA
//   requests, runs the DMR -> DMGI -> SACK handshake, waits for the current
//   bus cycle to finish, grants one requester round-robin and then releases
//   SACK. With no local request pending, DMGI is passed on as DMGO.
//
//   pin_clk   in  processor clock, all state on rising edge
//   pin_dclo  in  reset, asynchronous, active-high
//   bus       vm1_dma_arb_if.master (requests, grants and Qbus pins)
//
//   NREQ  number of local requesters (2..8)
//   TMO   REQ cycles allowed without DMGI before the request is aborted
// ----------------------------------------------------------------------------
module vm1_dma_arb #(
    parameter int NREQ = 4,
    parameter int TMO  = 15
) (
    input  logic          pin_clk,
    input  logic          pin_dclo,
    vm1_dma_arb_if.master bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_ACK   = 3'd2;
    localparam logic [2:0] S_GRANT = 3'd3;
    localparam logic [2:0] S_REL   = 3'd4;

    localparam logic [3:0]       TMO_CNT  = 4'(TMO);
    localparam logic [PTR_W-1:0] RR_RESET = PTR_W'(NREQ - 1);

    logic [2:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [PTR_W-1:0] rr_q, rr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             dmr_q, dmr_d;
    logic             sack_q, sack_d;
    logic             dmgo_q, dmgo_d;
    logic             busy_q, busy_d;
    logic             tmo_q, tmo_d;
    logic [PTR_W-1:0] winner;

    // Round-robin pick: first set request scanning upward from rr+1, wrapping.
    always_comb begin
        int unsigned idx;
        logic        found;
        winner = rr_q;
        found  = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(rr_q) + i) % NREQ;
            if (!found && bus.req[idx]) begin
                winner = PTR_W'(idx);
                found  = 1'b1;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no branch can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        tmo_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                // Another master holding SACK keeps us from requesting.
                if (|bus.req && !bus.pin_sack_in) begin
                    state_d = S_REQ;
                    cnt_d   = 4'd1;   // counter equals the REQ cycle number
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 4'd1;
                // DMGI takes priority over withdrawal and timeout.
                if (bus.pin_dmgi) begin
                    state_d = S_ACK;
                end else if (!(|bus.req)) begin
                    state_d = S_IDLE;
                end else if (cnt_q == TMO_CNT) begin
                    state_d = S_IDLE;
                    tmo_d   = 1'b1;
                end
            end
            S_ACK: begin
                if (!(|bus.req)) begin
                    state_d = S_REL;
                end else if (!bus.pin_sync_in && !bus.pin_rply_in) begin
                    state_d       = S_GRANT;
                    rr_d          = winner;
                    gnt_d         = '0;
                    gnt_d[winner] = 1'b1;
                end
            end
            S_GRANT: begin
                // Only the owner's request matters; rr_q holds the owner.
                if (!bus.req[rr_q]) begin
                    state_d = S_REL;
                    gnt_d   = '0;
                end
            end
            S_REL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change cleanly on
    // the clock edge and never glitch onto the open-collector drivers.
    always_comb begin
        dmr_d  = (state_d == S_REQ);
        sack_d = (state_d == S_ACK) || (state_d == S_GRANT);
        busy_d = (state_d != S_IDLE);
        dmgo_d = bus.pin_dmgi && (state_q == S_IDLE) && !(|bus.req);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge pin_clk or posedge pin_dclo) begin
        if (pin_dclo) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rr_q    <= RR_RESET;
            gnt_q   <= '0;
            dmr_q   <= 1'b0;
            sack_q  <= 1'b0;
            dmgo_q  <= 1'b0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            dmr_q   <= dmr_d;
            sack_q  <= sack_d;
            dmgo_q  <= dmgo_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.pin_dmr_out  = dmr_q;
    assign bus.pin_sack_out = sack_q;
    assign bus.pin_dmgo     = dmgo_q;
    assign bus.busy         = busy_q;
    assign bus.tmo          = tmo_q;
endmodule
